// File: rtl/vga_scan_gen.sv
// Raster scan timing master: pixel divider, h/v counters, and a one-pixel
// output pipeline that keeps sync, data enable and colour aligned.
module vga_scan_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned CLK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] hcounter,
  output logic [10:0] vcounter,
  input  logic [3:0]  color_in,
  output logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [3:0]  color_out,
  output logic        frame_start,
  output logic        line_start
);

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Reject timings the counters cannot represent.
  if (H_TOTAL == 0 || H_TOTAL > (1 << HW)) begin : g_h_total_chk
    $error("vga_scan_gen: horizontal total does not fit the 12-bit hcounter");
  end
  if (V_TOTAL == 0 || V_TOTAL > (1 << VW)) begin : g_v_total_chk
    $error("vga_scan_gen: vertical total does not fit the 11-bit vcounter");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
    $error("vga_scan_gen: CLK_DIV must be in 1..16");
  end

  logic [DW-1:0] div_q,  div_d;
  logic          pe_q,   pe_d;
  logic [HW-1:0] h_q,    h_d;
  logic [VW-1:0] v_q,    v_d;
  logic          hs_q,   hs_d;
  logic          vs_q,   vs_d;
  logic          de_q,   de_d;
  logic [CW-1:0] col_q,  col_d;
  logic          fs_q,   fs_d;
  logic          ls_q,   ls_d;

  logic [DW:0]   div_nxt;
  logic          h_last;
  logic          v_last;
  logic          vis;
  logic          hs_act;
  logic          vs_act;

  // Region decode on the counters currently on display.
  always_comb begin
    h_last = (h_q == HW'(H_TOTAL - 1));
    v_last = (v_q == VW'(V_TOTAL - 1));
    vis    = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs_act = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    vs_act = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
  end

  // Next-state: divider tick, counter advance and output pipeline.
  always_comb begin
    div_d   = div_q;
    pe_d    = 1'b0;
    h_d     = h_q;
    v_d     = v_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    de_d    = de_q;
    col_d   = col_q;
    fs_d    = 1'b0;
    ls_d    = 1'b0;

    div_nxt = (DW + 1)'(div_q) + (DW + 1)'(1);
    if (div_nxt == (DW + 1)'(CLK_DIV)) begin
      div_d = '0;
      pe_d  = 1'b1;
    end else begin
      div_d = div_nxt[DW-1:0];
    end

    if (pe_q) begin
      de_d  = vis;
      hs_d  = hs_act ? SYNC_POL : ~SYNC_POL;
      vs_d  = vs_act ? SYNC_POL : ~SYNC_POL;
      col_d = vis ? color_in : '0;

      if (h_last) begin
        h_d  = '0;
        ls_d = 1'b1;
        if (v_last) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      pe_q  <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      de_q  <= 1'b0;
      col_q <= '0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      pe_q  <= pe_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      col_q <= col_d;
      fs_q  <= fs_d;
      ls_q  <= ls_d;
    end
  end

  assign hcounter    = h_q;
  assign vcounter    = v_q;
  assign pix_en      = pe_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign color_out   = col_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: scoreboarded small-timing instance plus divider,
// mid-frame reset and sync-polarity instances sharing one clock.
module tb_vga_scan_gen;

  localparam int SHT = 15;
  localparam int SVT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: small timing, CLK_DIV=1, active-high syncs (scoreboarded)
  logic        rst_a;
  logic [11:0] hc_a;
  logic [10:0] vc_a;
  logic [3:0]  cin_a, cout_a;
  logic        pe_a, hs_a, vs_a, de_a, fs_a, ls_a;
  logic        force_f;
  assign cin_a = force_f ? 4'hF : hc_a[3:0];

  // b: small timing, CLK_DIV=3
  logic        rst_b;
  logic [11:0] hc_b;
  logic [10:0] vc_b;
  logic [3:0]  cout_b;
  logic        pe_b, hs_b, vs_b, de_b, fs_b, ls_b;

  // c: default timing, active-low syncs
  logic        rst_c;
  logic [11:0] hc_c;
  logic [10:0] vc_c;
  logic [3:0]  cout_c;
  logic        pe_c, hs_c, vs_c, de_c, fs_c, ls_c;

  // d: small timing, active-low syncs
  logic        rst_d;
  logic [11:0] hc_d;
  logic [10:0] vc_d;
  logic [3:0]  cout_d;
  logic        pe_d, hs_d, vs_d, de_d, fs_d, ls_d;

  vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                 .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .CLK_DIV(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .hcounter(hc_a), .vcounter(vc_a), .color_in(cin_a),
    .pix_en(pe_a), .hsync(hs_a), .vsync(vs_a), .de(de_a), .color_out(cout_a),
    .frame_start(fs_a), .line_start(ls_a));

  vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                 .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .CLK_DIV(3)) u_dut_b (
    .clk(clk), .rst(rst_b), .hcounter(hc_b), .vcounter(vc_b), .color_in(hc_b[3:0]),
    .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b), .de(de_b), .color_out(cout_b),
    .frame_start(fs_b), .line_start(ls_b));

  vga_scan_gen #(.SYNC_POL(1'b0)) u_dut_c (
    .clk(clk), .rst(rst_c), .hcounter(hc_c), .vcounter(vc_c), .color_in(4'h5),
    .pix_en(pe_c), .hsync(hs_c), .vsync(vs_c), .de(de_c), .color_out(cout_c),
    .frame_start(fs_c), .line_start(ls_c));

  vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                 .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .CLK_DIV(1)) u_dut_d (
    .clk(clk), .rst(rst_d), .hcounter(hc_d), .vcounter(vc_d), .color_in(4'hA),
    .pix_en(pe_d), .hsync(hs_d), .vsync(vs_d), .de(de_d), .color_out(cout_d),
    .frame_start(fs_d), .line_start(ls_d));

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [3:0] col;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs    = 0;

  // Reference model state for instance a
  int   mh, mv, ka;
  logic mpe, mls, mfs, mde, mhs, mvs;
  logic [3:0] mcol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance the model across one clock edge.
  task automatic model_edge_a(input logic r);
    exp_t e;
    if (r) begin
      mh = 0; mv = 0; ka = 0;
      mpe = 1'b0; mls = 1'b0; mfs = 1'b0;
      mde = 1'b0; mhs = 1'b0; mvs = 1'b0; mcol = 4'h0;
      q.delete();
    end else begin
      ka++;
      mls = 1'b0;
      mfs = 1'b0;
      if (mpe) begin
        chk("a_sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          mde = e.de; mhs = e.hs; mvs = e.vs; mcol = e.col;
        end
        if (mh == SHT - 1) begin
          mh = 0;
          mls = 1'b1;
          if (mv == SVT - 1) begin
            mv = 0;
            mfs = 1'b1;
          end else begin
            mv++;
          end
        end else begin
          mh++;
        end
      end
      mpe = 1'b1;
    end
  endtask

  // Expected registered outputs for the coordinate presented at the next edge.
  task automatic push_a();
    exp_t e;
    logic vis;
    if (mpe) begin
      vis   = (mh < 8) && (mv < 4);
      e.de  = vis;
      e.hs  = (mh >= 10) && (mh <= 12);
      e.vs  = (mv >= 5) && (mv <= 6);
      e.col = vis ? (force_f ? 4'hF : 4'(mh)) : 4'h0;
      q.push_back(e);
    end
  endtask

  task automatic check_a();
    chk("a_hcounter",    32'(hc_a),   32'(mh));
    chk("a_vcounter",    32'(vc_a),   32'(mv));
    chk("a_pix_en",      32'(pe_a),   32'(mpe));
    chk("a_line_start",  32'(ls_a),   32'(mls));
    chk("a_frame_start", 32'(fs_a),   32'(mfs));
    chk("a_de",          32'(de_a),   32'(mde));
    chk("a_hsync",       32'(hs_a),   32'(mhs));
    chk("a_vsync",       32'(vs_a),   32'(mvs));
    chk("a_color_out",   32'(cout_a), 32'(mcol));
  endtask

  initial begin
    int nvd, nhd, nhc1, nhc2, nvc, idx;
    bit mid_done;
    nvd = 0; nhd = 0; nhc1 = 0; nhc2 = 0; nvc = 0; mid_done = 1'b0;
    force_f = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;

    repeat (5) begin
      @(negedge clk);
      model_edge_a(1'b1);
      check_a();
      chk("b_rst_hcounter", 32'(hc_b), 32'd0);
      chk("b_rst_vcounter", 32'(vc_b), 32'd0);
      chk("b_rst_pix_en",   32'(pe_b), 32'd0);
      chk("b_rst_hsync",    32'(hs_b), 32'd0);
      chk("b_rst_vsync",    32'(vs_b), 32'd0);
      chk("b_rst_de",       32'(de_b), 32'd0);
      chk("c_rst_hsync",    32'(hs_c), 32'd1);
      chk("c_rst_vsync",    32'(vs_c), 32'd1);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    push_a();

    for (int k = 1; k <= 2082; k++) begin
      @(negedge clk);
      model_edge_a(rst_a);
      check_a();

      // Divider: first tick on the 3rd edge after release, period 3
      if (k <= 45) begin
        idx = (k - 1) / 3;
        chk("b_pix_en",   32'(pe_b), 32'(k % 3 == 0));
        chk("b_hcounter", 32'(hc_b), 32'(idx % 15));
        chk("b_vcounter", 32'(vc_b), 32'((idx / 15) % 8));
      end

      if (k >= 3 && k <= 122) begin
        if (vs_d === 1'b0) nvd++;
        if (hs_d === 1'b0) nhd++;
      end
      if (k == 122) begin
        chk("d_vsync_low_cycles", 32'(nvd), 32'd30);
        chk("d_hsync_low_cycles", 32'(nhd), 32'd24);
      end

      if (k >= 3) begin
        if (hs_c === 1'b0) begin
          if (k <= 1042) nhc1++;
          else nhc2++;
        end
        if (vs_c === 1'b0) nvc++;
      end
      if (k == 1042) chk("c_hsync_low_line0", 32'(nhc1), 32'd120);
      if (k == 2082) begin
        chk("c_hsync_low_line1", 32'(nhc2), 32'd120);
        chk("c_vsync_idle_high", 32'(nvc), 32'd0);
      end

      // Drive stimulus for the next edge
      force_f = (k >= 240) && (k < 370);
      if (k >= 380 && !mid_done && mh == 11 && mv == 5) begin
        rst_a = 1'b1;
        mid_done = 1'b1;
      end else begin
        rst_a = 1'b0;
      end
      push_a();
    end

    chk("a_mid_reset_applied", 32'(mid_done), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
